spdif_tx_sched: RTL

Sample scheduler that feeds spdif_tx from two sources: a PCM stream (src0) and an IEC 61937 burst stream (src1).
- Each source has a small FIFO.
- Frames are popped on spdif_tx ack, and an audio_l/audio_r/mode/valid holding register is driven.
- Source changes occur only on 192-frame block boundaries, so channel status stays consistent within a block.
- Underruns are handled by muting with valid=0.

---
 rtl/spdif_tx_sched.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/spdif_tx_sched.sv
// spdif_tx_sched: feeds spdif_tx from a PCM source (src0) and an IEC 61937
// burst source (src1). Each source has a small FIFO. The frame source
// changes only on 192-frame channel-status block boundaries. An empty
// active FIFO mutes the frame with valid=0 and pulses underrun.
//
// Optional build macro SPDIF_TX_SCHED_UNDERRUN_CNT_EN adds a saturating
// 16-bit underrun counter (underrun_cnt) with a synchronous clear
// (underrun_clr).
module spdif_tx_sched #(
    parameter int FIFO_AW = 2,
    parameter int BLK_LEN = 192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        sel,
    input  logic [23:0] src0_l,
    input  logic [23:0] src0_r,
    input  logic        src0_valid,
    output logic        src0_ready,
    input  logic [23:0] src1_l,
    input  logic [23:0] src1_r,
    input  logic        src1_valid,
    output logic        src1_ready,
    output logic [23:0] tx_audio_l,
    output logic [23:0] tx_audio_r,
    output logic        tx_mode,
    output logic        tx_valid,
    input  logic        tx_ack,
    output logic [1:0]  cur_src,
    output logic [7:0]  frame_idx,
`ifdef SPDIF_TX_SCHED_UNDERRUN_CNT_EN
    input  logic        underrun_clr,
    output logic [15:0] underrun_cnt,
`endif
    output logic        underrun
);

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [7:0]       LAST_IDX = 8'(BLK_LEN - 1);

    // Encoding matches the cur_src output directly.
    typedef enum logic [1:0] {
        ST_MUTE = 2'd0,
        ST_PCM  = 2'd1,
        ST_IEC  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Per-source FIFOs (index 0 = PCM, index 1 = IEC), entry = {R, L}
    // ------------------------------------------------------------------
    logic [47:0]        mem_q    [2][DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q [2];
    logic [FIFO_AW-1:0] rd_ptr_q [2];
    logic [FIFO_AW:0]   level_q  [2];

    logic [1:0]  push_s;
    logic [1:0]  pop_s;
    logic [1:0]  full_s;
    logic [1:0]  empty_s;
    logic [47:0] wdata_s [2];
    logic [47:0] head_s  [2];

    // FIFO status flags and combinational head read.
    always_comb begin
        wdata_s[0] = {src0_r, src0_l};
        wdata_s[1] = {src1_r, src1_l};
        for (int s = 0; s < 2; s++) begin
            full_s[s]  = (level_q[s] == DEPTH_C);
            empty_s[s] = (level_q[s] == '0);
            head_s[s]  = mem_q[s][rd_ptr_q[s]];
        end
    end

    // Ready is plain !full: a pop in the same cycle does not open a slot.
    assign push_s[0]  = src0_valid & ~full_s[0];
    assign push_s[1]  = src1_valid & ~full_s[1];
    assign src0_ready = ~full_s[0];
    assign src1_ready = ~full_s[1];

    // FIFO storage, pointers and fill levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                level_q[s]  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[s][i] <= 48'h0;
                end
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push_s[s]) begin
                    mem_q[s][wr_ptr_q[s]] <= wdata_s[s];
                    wr_ptr_q[s]           <= wr_ptr_q[s] + 1'b1;
                end
                // A pop always takes the pre-push head.
                if (pop_s[s]) begin
                    rd_ptr_q[s] <= rd_ptr_q[s] + 1'b1;
                end
                case ({push_s[s], pop_s[s]})
                    2'b10:   level_q[s] <= level_q[s] + 1'b1;
                    2'b01:   level_q[s] <= level_q[s] - 1'b1;
                    default: level_q[s] <= level_q[s];
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Scheduler
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [7:0]  frame_idx_q, frame_idx_d;
    logic [23:0] tx_l_q, tx_l_d;
    logic [23:0] tx_r_q, tx_r_d;
    logic        tx_mode_q, tx_mode_d;
    logic        tx_valid_q, tx_valid_d;
    logic        underrun_q, underrun_d;
    logic        boundary_s;

    // Source selection is re-evaluated only on the block boundary ack;
    // an empty requested FIFO parks the block in MUTE until the next one.
    always_comb begin
        boundary_s = tx_ack && (frame_idx_q == LAST_IDX);
        state_d    = state_q;
        if (boundary_s) begin
            if (!en) begin
                state_d = ST_MUTE;
            end else if (sel) begin
                state_d = empty_s[1] ? ST_MUTE : ST_IEC;
            end else begin
                state_d = empty_s[0] ? ST_MUTE : ST_PCM;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Frame counter and output-register load, driven from the next state so
    // the first frame of a new block already comes from the new source.
    always_comb begin
        frame_idx_d = frame_idx_q;
        pop_s       = 2'b00;
        tx_l_d      = tx_l_q;
        tx_r_d      = tx_r_q;
        tx_mode_d   = tx_mode_q;
        tx_valid_d  = tx_valid_q;
        underrun_d  = 1'b0;
        if (tx_ack) begin
            frame_idx_d = boundary_s ? 8'd0 : (frame_idx_q + 8'd1);
            case (state_d)
                ST_PCM: begin
                    tx_mode_d = 1'b0;
                    if (!empty_s[0]) begin
                        pop_s[0]         = 1'b1;
                        {tx_r_d, tx_l_d} = head_s[0];
                        tx_valid_d       = 1'b1;
                    end else begin
                        {tx_r_d, tx_l_d} = 48'h0;
                        tx_valid_d       = 1'b0;
                        underrun_d       = 1'b1;
                    end
                end
                ST_IEC: begin
                    tx_mode_d = 1'b1;
                    if (!empty_s[1]) begin
                        pop_s[1]         = 1'b1;
                        {tx_r_d, tx_l_d} = head_s[1];
                        tx_valid_d       = 1'b1;
                    end else begin
                        {tx_r_d, tx_l_d} = 48'h0;
                        tx_valid_d       = 1'b0;
                        underrun_d       = 1'b1;
                    end
                end
                default: begin
                    {tx_r_d, tx_l_d} = 48'h0;
                    tx_mode_d        = 1'b0;
                    tx_valid_d       = 1'b0;
                end
            endcase
        end else begin
            frame_idx_d = frame_idx_q;
        end
    end

    // State, frame counter and registered spdif_tx holding outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_MUTE;
            frame_idx_q <= 8'd0;
            tx_l_q      <= 24'h0;
            tx_r_q      <= 24'h0;
            tx_mode_q   <= 1'b0;
            tx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_idx_q <= frame_idx_d;
            tx_l_q      <= tx_l_d;
            tx_r_q      <= tx_r_d;
            tx_mode_q   <= tx_mode_d;
            tx_valid_q  <= tx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign tx_audio_l = tx_l_q;
    assign tx_audio_r = tx_r_q;
    assign tx_mode    = tx_mode_q;
    assign tx_valid   = tx_valid_q;
    assign cur_src    = state_q;
    assign frame_idx  = frame_idx_q;
    assign underrun   = underrun_q;

`ifdef SPDIF_TX_SCHED_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    // Saturating underrun counter; clear takes priority over a count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt_q <= 16'h0000;
        end else if (underrun_clr) begin
            underrun_cnt_q <= 16'h0000;
        end else if (underrun_q && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'h0001;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

endmodule
